fir_coeff_loader: RTL and testbench
===================================

Name: fir_coeff_loader

Overview:
- Runtime coefficient controller for the pipelined transposed-form FIR. Drives the FIR's parallel tap-coefficient array.
- Accepts a serial stream of NUM_TAPS coefficients over a valid/ready handshake into a shadow bank, then commits it atomically to the active bank on a frame-boundary strobe.
- Reports completion and errors, and flags the settling window during which FIR output mixes old and new coefficients.

Parameters:
- TAP_COEFF_WIDTH, 5, width of one signed coefficient
- NUM_TAPS, 50, number of taps; also the exact word count of one load
- SETTLE_CYCLES, NUM_TAPS+3, cycles settling stays high after a commit (FIR fill latency)

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- cfg_start  input  1  one-cycle pulse that begins a load; honoured only in IDLE
- cfg_valid  input  1  cfg_data is valid
- cfg_ready  output  1  loader accepts a word this cycle
- cfg_data  input  TAP_COEFF_WIDTH signed  coefficient word
- cfg_last  input  1  marks the final word of a load
- swap_en  input  1  frame-boundary strobe; commits a pending bank
- tap_coeffs  output  TAP_COEFF_WIDTH signed x [NUM_TAPS-1:0]  active bank, wired to the FIR
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse on commit
- err  output  1  one-cycle pulse on a framing error
- settling  output  1  FIR output not yet consistent with the active bank

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset:
  - FSM goes to IDLE; word counter = 0.
  - Shadow and active banks all 0.
  - cfg_ready, busy, done, err and settling are all 0.
  - Reset mid-load or mid-settle discards everything.
- FSM states: IDLE, LOAD, PEND, SETTLE.
- IDLE:
  - cfg_ready = 0.
  - cfg_start -> LOAD, counter cleared.
- LOAD:
  - cfg_ready = 1 (registered, asserted the cycle after entry).
  - Transfer occurs when cfg_valid && cfg_ready: shadow[counter] <= cfg_data, counter++.
  - The first word goes to tap index 0.
  - Transfer with cfg_last at counter == NUM_TAPS-1 -> PEND.
  - Transfer with cfg_last at counter < NUM_TAPS-1 -> err pulse, IDLE, active untouched.
  - Transfer at counter == NUM_TAPS-1 without cfg_last -> err pulse, IDLE, active untouched.
  - cfg_start while in LOAD is ignored.
- PEND:
  - cfg_ready = 0; waits for swap_en.
  - On a clock with swap_en = 1: active <= shadow (all taps in the same edge), done pulses next cycle, enter SETTLE with counter loaded to SETTLE_CYCLES-1.
  - swap_en in any other state has no effect.
- SETTLE:
  - settling = 1; counter decrements each cycle.
  - At counter 0 -> IDLE; settling falls the same edge.
  - cfg_start during SETTLE is ignored. A new load requires IDLE.
- tap_coeffs is driven directly from active-bank registers, with no combinational path from inputs. The FIR's own coefficient flop adds its latency downstream.
- done and err never assert in the same cycle.
- busy is 1 in LOAD, PEND and SETTLE.

Optional Feature:
- FIR_COEFF_READBACK_EN defined:
  - Adds ports rd_addr (input, clog2(NUM_TAPS)) and rd_data (output, TAP_COEFF_WIDTH signed).
  - rd_data = active[rd_addr], registered, 1-cycle latency, reset to 0.
  - rd_addr >= NUM_TAPS returns 0.
- FIR_COEFF_READBACK_EN undefined: the ports do not exist and no logic is added.

Test Plan:
- Load after reset:
  - Stimulus: cfg_start, then 50 words with word i = (i%16)-8 and cfg_last on i=49 with continuous valid, then swap_en 3 cycles later.
  - Required: tap_coeffs[0] = -8, tap_coeffs[15] = 7, tap_coeffs[49] = -7. done pulses once. settling is high for exactly 53 cycles, then busy = 0.
- Pending hold:
  - Stimulus: complete a load, keep swap_en low for 100 cycles.
  - Required: tap_coeffs keeps its prior values (all 0 after reset), busy = 1, cfg_ready = 0. swap_en then commits.
- Early cfg_last:
  - Stimulus: cfg_last on word 10.
  - Required: err pulses, FSM returns to IDLE, active bank unchanged, a following swap_en has no effect.
- Missing cfg_last:
  - Stimulus: 50 words, none marked last.
  - Required: err pulses on word 50's transfer, active bank unchanged.
- Backpressure and bubbles:
  - Stimulus: random cfg_valid gaps during a load.
  - Required: only handshaked words are stored, in order; the result matches the gap-free load.
- Reset mid-operation:
  - Stimulus: rst asserted asynchronously during LOAD, then separately during SETTLE.
  - Required: all outputs 0 immediately, tap_coeffs all 0.
  - With FIR_COEFF_READBACK_EN: rd_addr = 15 after a commit returns 7 one cycle later; rd_addr = 60 returns 0.

Source files
------------

// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if: config stream, swap strobe and coefficient/status bus; FIR_COEFF_READBACK_EN adds rd_addr/rd_data
interface fir_coeff_loader_if #(
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS = 50
);
  logic cfg_start;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_last;
  logic signed [TAP_COEFF_WIDTH-1:0] cfg_data;
  logic swap_en;
  logic signed [TAP_COEFF_WIDTH-1:0] tap_coeffs [NUM_TAPS-1:0];
  logic busy;
  logic done;
  logic err;
  logic settling;
`ifdef FIR_COEFF_READBACK_EN
  logic [$clog2(NUM_TAPS)-1:0] rd_addr;
  logic signed [TAP_COEFF_WIDTH-1:0] rd_data;
  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, swap_en, rd_addr,
    input cfg_ready, tap_coeffs, busy, done, err, settling, rd_data
  );
  modport slave (
    input cfg_start, cfg_valid, cfg_data, cfg_last, swap_en, rd_addr,
    output cfg_ready, tap_coeffs, busy, done, err, settling, rd_data
  );
`else
  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_last, swap_en,
    input cfg_ready, tap_coeffs, busy, done, err, settling
  );
  modport slave (
    input cfg_start, cfg_valid, cfg_data, cfg_last, swap_en,
    output cfg_ready, tap_coeffs, busy, done, err, settling
  );
`endif
endinterface

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: serial coefficient load into a shadow bank, atomic commit on swap_en; FIR_COEFF_READBACK_EN adds active-bank readback
module fir_coeff_loader #(
  parameter int TAP_COEFF_WIDTH = 5,
  parameter int NUM_TAPS = 50,
  parameter int SETTLE_CYCLES = NUM_TAPS + 3
) (
  input logic clk,
  input logic rst,
  fir_coeff_loader_if.slave bus
);
  localparam int AW = $clog2(NUM_TAPS);
  localparam int CW = $clog2((NUM_TAPS > SETTLE_CYCLES ? NUM_TAPS : SETTLE_CYCLES) + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_TAPS - 1);
  localparam logic [CW-1:0] SETTLE_INIT = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, LOAD, PEND, SETTLE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic signed [TAP_COEFF_WIDTH-1:0] shadow [NUM_TAPS-1:0];
  logic signed [TAP_COEFF_WIDTH-1:0] active [NUM_TAPS-1:0];
  logic ready, busy, done, err, settling;
  logic xfer, frame_ok;
  assign xfer = bus.cfg_valid && ready;
  assign frame_ok = bus.cfg_last && cnt == LAST_IDX;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shadow <= '{default: '0};
      active <= '{default: '0};
      ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      settling <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (bus.cfg_start) begin
          state <= LOAD;
          cnt <= '0;
          ready <= 1'b1;
          busy <= 1'b1;
        end
        LOAD: if (xfer) begin
          shadow[cnt[AW-1:0]] <= bus.cfg_data;
          cnt <= cnt + 1'b1;
          // any framing violation aborts to IDLE without touching the active bank
          if (bus.cfg_last || cnt == LAST_IDX) begin
            ready <= 1'b0;
            state <= frame_ok ? PEND : IDLE;
            busy <= frame_ok;
            err <= !frame_ok;
          end
        end
        PEND: if (bus.swap_en) begin
          active <= shadow;
          done <= 1'b1;
          settling <= 1'b1;
          cnt <= SETTLE_INIT;
          state <= SETTLE;
        end
        SETTLE: if (cnt == '0) begin
          state <= IDLE;
          settling <= 1'b0;
          busy <= 1'b0;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  assign bus.cfg_ready = ready;
  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.settling = settling;
  assign bus.tap_coeffs = active;
`ifdef FIR_COEFF_READBACK_EN
  logic signed [TAP_COEFF_WIDTH-1:0] rd_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) rd_data <= '0;
    else rd_data <= ({1'b0, bus.rd_addr} < (AW+1)'(NUM_TAPS)) ? active[bus.rd_addr] : '0;
  assign bus.rd_data = rd_data;
`endif
endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader: scoreboard bench for fir_coeff_loader; covers FIR_COEFF_READBACK_EN when defined
module tb_fir_coeff_loader;
  localparam int W = 5;
  localparam int N = 50;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fir_coeff_loader_if #(.TAP_COEFF_WIDTH(W), .NUM_TAPS(N)) bus ();
  fir_coeff_loader #(.TAP_COEFF_WIDTH(W), .NUM_TAPS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic signed [W-1:0] exp_q [$];
  logic signed [W-1:0] act_model [N];

  function automatic logic signed [W-1:0] coeff(int i, int p);
    return W'(p == 0 ? (i % 16) - 8 : ((i * 7 + p) % 32) - 16);
  endfunction

  function automatic int tap_diff();
    int d = 0;
    for (int i = 0; i < N; i++) if (bus.tap_coeffs[i] !== act_model[i]) d++;
    return d;
  endfunction

  task automatic init_inputs();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data = '0;
    bus.cfg_last = 1'b0;
    bus.swap_en = 1'b0;
`ifdef FIR_COEFF_READBACK_EN
    bus.rd_addr = '0;
`endif
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) act_model[i] = '0;
    exp_q.delete();
  endtask

  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    clear_model();
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic pop_model();
    for (int i = 0; i < N; i++)
      if (exp_q.size() > 0) act_model[i] = exp_q.pop_front();
      else act_model[i] = 'x;
  endtask

  task automatic load(input int n, input int last_at, input int p, input bit gaps, input bit push);
    int i = 0;
    int t = 0;
    @(negedge clk) bus.cfg_start = 1'b1;
    @(negedge clk) bus.cfg_start = 1'b0;
    while (i < n && t < 3000) begin
      bus.cfg_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.cfg_data = bus.cfg_valid ? coeff(i, p) : W'($urandom);
      bus.cfg_last = bus.cfg_valid ? (i == last_at) : 1'($urandom_range(0, 1));
      if (bus.cfg_valid && bus.cfg_ready) begin
        if (push) exp_q.push_back(coeff(i, p));
        i++;
      end
      t++;
      @(negedge clk);
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_last = 1'b0;
    n_cmp++;
    if (i != n) begin
      n_bad++;
      $display("FAIL load_words: accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic swap();
    bus.swap_en = 1'b1;
    @(negedge clk) bus.swap_en = 1'b0;
  endtask

  task automatic wait_settle(output int cyc, output int dones);
    cyc = 0;
    dones = 0;
    while (bus.settling && cyc < 200) begin
      cyc++;
      if (bus.done) dones++;
      @(negedge clk);
    end
    if (bus.done) dones++;
  endtask

  task automatic test_reset();
    init_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got=%b want=00000", {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling});
    end
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL reset_taps: differing=%0d want=0", tap_diff()); end
`ifdef FIR_COEFF_READBACK_EN
    n_cmp++;
    if (bus.rd_data !== '0) begin n_bad++; $display("FAIL reset_rd_data: got=%0d want=0", bus.rd_data); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_load_after_reset();
    int cyc, dn;
    load(N, N - 1, 0, 1'b0, 1'b1);
    n_cmp++;
    if ({bus.err, bus.busy, bus.cfg_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL load_pend: err/busy/ready got=%b want=010", {bus.err, bus.busy, bus.cfg_ready});
    end
    repeat (2) @(negedge clk);
    swap();
    n_cmp++;
    if ({bus.done, bus.settling} !== 2'b11) begin
      n_bad++;
      $display("FAIL load_commit: done/settling got=%b want=11", {bus.done, bus.settling});
    end
    pop_model();
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL load_taps: differing=%0d want=0", tap_diff()); end
    n_cmp++;
    if ({bus.tap_coeffs[0], bus.tap_coeffs[15], bus.tap_coeffs[49]} !== {5'b11000, 5'b00111, 5'b11001}) begin
      n_bad++;
      $display("FAIL load_spot: taps0/15/49 got=%0d/%0d/%0d want=-8/7/-7",
               bus.tap_coeffs[0], bus.tap_coeffs[15], bus.tap_coeffs[49]);
    end
    wait_settle(cyc, dn);
    n_cmp++;
    if (cyc != 53) begin n_bad++; $display("FAIL settle_len: got=%0d want=53", cyc); end
    n_cmp++;
    if (dn != 1) begin n_bad++; $display("FAIL done_count: got=%0d want=1", dn); end
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL settle_idle: busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_pending_hold();
    int bad_cyc = 0;
    int cyc, dn;
    pulse_rst();
    load(N, N - 1, 1, 1'b0, 1'b1);
    for (int c = 0; c < 100; c++) begin
      if ({bus.busy, bus.cfg_ready, bus.settling} !== 3'b100 || tap_diff() != 0) bad_cyc++;
      @(negedge clk);
    end
    n_cmp++;
    if (bad_cyc != 0) begin n_bad++; $display("FAIL pend_hold: bad_cycles=%0d want=0", bad_cyc); end
    swap();
    n_cmp++;
    if (bus.done !== 1'b1) begin n_bad++; $display("FAIL pend_commit: done got=%b want=1", bus.done); end
    pop_model();
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL pend_taps: differing=%0d want=0", tap_diff()); end
    wait_settle(cyc, dn);
    n_cmp++;
    if (cyc != 53 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL pend_settle: cycles=%0d busy=%b want 53/0", cyc, bus.busy);
    end
  endtask

  task automatic test_early_last();
    load(11, 10, 2, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.err, bus.done, bus.busy, bus.cfg_ready} !== 4'b1000) begin
      n_bad++;
      $display("FAIL early_err: err/done/busy/ready got=%b want=1000", {bus.err, bus.done, bus.busy, bus.cfg_ready});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.err !== 1'b0) begin n_bad++; $display("FAIL early_err_pulse: err got=%b want=0", bus.err); end
    swap();
    n_cmp++;
    if ({bus.done, bus.settling, bus.busy} !== 3'b000) begin
      n_bad++;
      $display("FAIL early_swap: done/settling/busy got=%b want=000", {bus.done, bus.settling, bus.busy});
    end
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL early_taps: differing=%0d want=0", tap_diff()); end
  endtask

  task automatic test_missing_last();
    load(N, -1, 3, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.err, bus.done, bus.busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL missing_err: err/done/busy got=%b want=100", {bus.err, bus.done, bus.busy});
    end
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL missing_taps: differing=%0d want=0", tap_diff()); end
  endtask

  task automatic test_backpressure();
    int cyc, dn;
    load(N, N - 1, 0, 1'b1, 1'b1);
    n_cmp++;
    if ({bus.err, bus.busy, bus.cfg_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_pend: err/busy/ready got=%b want=010", {bus.err, bus.busy, bus.cfg_ready});
    end
    swap();
    pop_model();
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL bp_taps: differing=%0d want=0", tap_diff()); end
    n_cmp++;
    if (bus.tap_coeffs[15] !== 5'b00111) begin
      n_bad++;
      $display("FAIL bp_spot: tap15 got=%0d want=7", bus.tap_coeffs[15]);
    end
    wait_settle(cyc, dn);
    n_cmp++;
    if (cyc != 53 || dn != 1) begin n_bad++; $display("FAIL bp_settle: cycles=%0d dones=%0d want 53/1", cyc, dn); end
  endtask

  task automatic test_reset_mid();
    load(20, -1, 4, 1'b0, 1'b0);
    n_cmp++;
    if ({bus.busy, bus.cfg_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_load_state: busy/ready got=%b want=11", {bus.busy, bus.cfg_ready});
    end
    #2 rst = 1'b1;
    clear_model();
    #1;
    n_cmp++;
    if ({bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling} !== 5'b0 || tap_diff() != 0) begin
      n_bad++;
      $display("FAIL rst_in_load: flags=%b tap_diff=%0d want 00000/0",
               {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling}, tap_diff());
    end
    @(negedge clk) rst = 1'b0;
    load(N, N - 1, 5, 1'b0, 1'b1);
    swap();
    pop_model();
    n_cmp++;
    if (tap_diff() != 0) begin n_bad++; $display("FAIL mid_commit_taps: differing=%0d want=0", tap_diff()); end
    repeat (10) @(negedge clk);
    n_cmp++;
    if ({bus.settling, bus.busy} !== 2'b11) begin
      n_bad++;
      $display("FAIL mid_settle_state: settling/busy got=%b want=11", {bus.settling, bus.busy});
    end
    #2 rst = 1'b1;
    clear_model();
    #1;
    n_cmp++;
    if ({bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling} !== 5'b0 || tap_diff() != 0) begin
      n_bad++;
      $display("FAIL rst_in_settle: flags=%b tap_diff=%0d want 00000/0",
               {bus.cfg_ready, bus.busy, bus.done, bus.err, bus.settling}, tap_diff());
    end
    @(negedge clk) rst = 1'b0;
  endtask

`ifdef FIR_COEFF_READBACK_EN
  task automatic test_readback();
    int cyc, dn;
    load(N, N - 1, 0, 1'b0, 1'b1);
    swap();
    pop_model();
    wait_settle(cyc, dn);
    bus.rd_addr = 6'd15;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_data !== 5'b00111) begin n_bad++; $display("FAIL rd_15: got=%0d want=7", bus.rd_data); end
    bus.rd_addr = 6'd49;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_data !== 5'b11001) begin n_bad++; $display("FAIL rd_49: got=%0d want=-7", bus.rd_data); end
    bus.rd_addr = 6'd60;
    @(negedge clk);
    n_cmp++;
    if (bus.rd_data !== 5'b00000) begin n_bad++; $display("FAIL rd_60: got=%0d want=0", bus.rd_data); end
  endtask
`endif

  initial begin
    test_reset();
    test_load_after_reset();
    test_pending_hold();
    test_early_last();
    test_missing_last();
    test_backpressure();
    test_reset_mid();
`ifdef FIR_COEFF_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1);
  end
endmodule
